aes_stream_packer: RTL and testbench

- Ingress stage placed directly upstream of the AES input FIFO.
- Accepts a 32-bit AXI-stream packet. Word 0 is the AES command word; the remaining words are payload.
- Packs payload words into 128-bit AES blocks, writes each block into the input FIFO, and tells the AES controller when the packet is fully staged.
- Holds off the next packet until the output side releases it.

---
 rtl/aes_stream_packer_if.sv | 9 +
 rtl/aes_stream_packer.sv | 137 +++++++++++++
 tb/tb_aes_stream_packer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_stream_packer_if.sv
// aes_stream_packer_if: 32-bit AXI-stream bundle feeding the AES packer
interface aes_stream_packer_if #(parameter int W = 32);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tlast;
  logic         tready;
  modport master (output tdata, tvalid, tlast, input tready);
  modport slave (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/aes_stream_packer.sv
// aes_stream_packer: packs an AXI-stream packet (cmd word + payload) into 128-bit AES blocks for the input FIFO
module aes_stream_packer #(
  parameter int C_S_AXIS_TDATA_WIDTH = 32,
  parameter int BLOCK_WIDTH = 128,
  parameter int MAX_BLOCKS = 2050,
  parameter int BLK_CNT_WIDTH = 12
) (
  input  logic                            clk,
  input  logic                            reset,
  aes_stream_packer_if.slave              s00_axis,
  input  logic                            in_fifo_full,
  output logic [BLOCK_WIDTH-1:0]          in_fifo_data,
  output logic                            in_fifo_w_e,
  output logic [C_S_AXIS_TDATA_WIDTH-1:0] axis_cmd,
  output logic                            cmd_valid,
  output logic [BLK_CNT_WIDTH-1:0]        blk_cnt,
  output logic                            axis_slave_done,
  input  logic                            axis_master_done,
  output logic                            err_partial,
  output logic                            err_overflow
);
  typedef enum logic [2:0] {S_CMD, S_PAYLOAD, S_FLUSH, S_DONE, S_WAIT} state_t;
  state_t state_q, state_d;
  logic [1:0]                      word_idx_q, word_idx_d;
  logic [BLOCK_WIDTH-1:0]          blk_q, blk_d;
  logic [BLOCK_WIDTH-1:0]          data_q, data_d;
  logic                            pend_q, pend_d;
  logic [BLK_CNT_WIDTH-1:0]        cnt_q, cnt_d;
  logic [C_S_AXIS_TDATA_WIDTH-1:0] cmd_q, cmd_d;
  logic                            cmd_valid_q, cmd_valid_d;
  logic                            done_q, done_d;
  logic                            perr_q, perr_d;
  logic                            oerr_q, oerr_d;
  logic                            tready, hs, w_e, ovf_hit, slot_free;
  // A staged block is written as soon as the FIFO has room; the slot frees the same cycle it is written
  assign w_e       = pend_q && !in_fifo_full;
  assign slot_free = !pend_q || !in_fifo_full;
  assign hs        = s00_axis.tvalid && tready;
  assign ovf_hit   = !oerr_q && word_idx_q == 2'd0 && cnt_q == BLK_CNT_WIDTH'(MAX_BLOCKS);
  // State register plus all datapath flops
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q     <= S_CMD;
      word_idx_q  <= '0;
      blk_q       <= '0;
      data_q      <= '0;
      pend_q      <= 1'b0;
      cnt_q       <= '0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      done_q      <= 1'b0;
      perr_q      <= 1'b0;
      oerr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_idx_q  <= word_idx_d;
      blk_q       <= blk_d;
      data_q      <= data_d;
      pend_q      <= pend_d;
      cnt_q       <= cnt_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      done_q      <= done_d;
      perr_q      <= perr_d;
      oerr_q      <= oerr_d;
    end
  // Next-state: a payload tlast goes straight to S_DONE when the block is complete or we are dropping
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_CMD:     state_d = hs ? (s00_axis.tlast ? S_DONE : S_PAYLOAD) : S_CMD;
      S_PAYLOAD: state_d = (hs && s00_axis.tlast) ?
                           ((oerr_q || ovf_hit || word_idx_q == 2'd3) ? S_DONE : S_FLUSH) : S_PAYLOAD;
      S_FLUSH:   state_d = slot_free ? S_DONE : S_FLUSH;
      S_DONE:    state_d = slot_free ? S_WAIT : S_DONE;
      S_WAIT:    state_d = axis_master_done ? S_CMD : S_WAIT;
      default:   state_d = S_CMD;
    endcase
  end
  // Stream readiness: word 3 waits for FIFO room, dropped overflow words are always taken
  always_comb
    tready = state_q == S_CMD ? 1'b1 :
             state_q == S_PAYLOAD ? (oerr_q || !(word_idx_q == 2'd3 && in_fifo_full)) : 1'b0;
  // Datapath: command capture, word packing, block staging, counters and error flags
  always_comb begin
    word_idx_d  = word_idx_q;
    blk_d       = blk_q;
    data_d      = data_q;
    pend_d      = pend_q && in_fifo_full;
    cnt_d       = cnt_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    done_d      = 1'b0;
    perr_d      = perr_q;
    oerr_d      = oerr_q;
    if (state_q == S_CMD && hs) begin
      cmd_d       = s00_axis.tdata;
      cmd_valid_d = 1'b1;
      cnt_d       = '0;
      word_idx_d  = '0;
      blk_d       = '0;
      perr_d      = 1'b0;
      oerr_d      = 1'b0;
    end else if (state_q == S_PAYLOAD && hs && !oerr_q) begin
      if (ovf_hit)
        oerr_d = 1'b1;
      else begin
        word_idx_d = word_idx_q + 2'd1;
        if (word_idx_q == 2'd3) begin
          data_d = {blk_q[BLOCK_WIDTH-1:32], s00_axis.tdata};
          blk_d  = '0;
          pend_d = 1'b1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          blk_d[{~word_idx_q, 5'd0} +: 32] = s00_axis.tdata;
          perr_d = perr_q || s00_axis.tlast;
        end
      end
    end else if (state_q == S_FLUSH && slot_free) begin
      data_d     = blk_q;
      blk_d      = '0;
      pend_d     = 1'b1;
      cnt_d      = cnt_q + 1'b1;
      word_idx_d = '0;
    end else if (state_q == S_DONE && slot_free)
      done_d = 1'b1;
  end
  assign s00_axis.tready  = tready;
  assign in_fifo_data     = data_q;
  assign in_fifo_w_e      = w_e;
  assign axis_cmd         = cmd_q;
  assign cmd_valid        = cmd_valid_q;
  assign blk_cnt          = cnt_q;
  assign axis_slave_done  = done_q;
  assign err_partial      = perr_q;
  assign err_overflow     = oerr_q;
endmodule

// File: tb/tb_aes_stream_packer.sv
// tb_aes_stream_packer: randomized scoreboard bench for aes_stream_packer
module tb_aes_stream_packer;
  localparam int MAXB = 2;
  typedef struct packed {logic [11:0] cnt; logic perr; logic oerr;} done_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_fifo_full = 1'b0;
  logic axis_master_done = 1'b0;
  logic [127:0] in_fifo_data;
  logic in_fifo_w_e, cmd_valid, axis_slave_done, err_partial, err_overflow;
  logic [31:0] axis_cmd;
  logic [11:0] blk_cnt;
  logic [127:0] exp_blk[$];
  logic [31:0] exp_cmd[$];
  done_t exp_done[$];
  int checks = 0;
  int fails = 0;
  int done_cnt = 0;
  int cyc = 0;
  int done_cyc = 0;
  bit rand_full = 0;
  bit force_full = 0;
  aes_stream_packer_if s_if ();
  aes_stream_packer #(.MAX_BLOCKS(MAXB)) dut (
    .clk(clk), .reset(reset), .s00_axis(s_if), .in_fifo_full(in_fifo_full),
    .in_fifo_data(in_fifo_data), .in_fifo_w_e(in_fifo_w_e), .axis_cmd(axis_cmd),
    .cmd_valid(cmd_valid), .blk_cnt(blk_cnt), .axis_slave_done(axis_slave_done),
    .axis_master_done(axis_master_done), .err_partial(err_partial), .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // FIFO full generator: random backpressure or a directed hold
  initial forever begin
    @(posedge clk);
    #2;
    in_fifo_full = rand_full ? ($urandom_range(0, 2) == 0) : force_full;
  end
  // Monitor: pops scoreboard entries whenever the DUT presents a write, command or done
  always @(negedge clk) if (!reset) begin
    if (in_fifo_w_e) begin
      chk("write while full", in_fifo_full, 0);
      if (exp_blk.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected write: got %h, no block expected", in_fifo_data);
      end else chk("block data", in_fifo_data, exp_blk.pop_front());
    end
    if (cmd_valid) begin
      if (exp_cmd.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected cmd_valid: got %h", axis_cmd);
      end else chk("axis_cmd", axis_cmd, exp_cmd.pop_front());
      chk("blk_cnt cleared", blk_cnt, 0);
      chk("errors cleared", {err_partial, err_overflow}, 0);
    end
    if (axis_slave_done) begin
      if (exp_done.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected done: blk_cnt %0d", blk_cnt);
      end else begin
        done_t e;
        e = exp_done.pop_front();
        chk("blk_cnt at done", blk_cnt, e.cnt);
        chk("err_partial at done", err_partial, e.perr);
        chk("err_overflow at done", err_overflow, e.oerr);
      end
      chk("writes outstanding at done", exp_blk.size(), 0);
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
  end
  task automatic send_word(input logic [31:0] d, input logic l, output int acc);
    int t = 0;
    if ($urandom_range(0, 3) == 0) begin
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    s_if.tdata = d;
    s_if.tlast = l;
    s_if.tvalid = 1'b1;
    @(negedge clk);
    while (!s_if.tready && t < 300) begin
      @(negedge clk);
      t++;
    end
    acc = cyc;
    chk("tready timeout", s_if.tready, 1);
    @(posedge clk);
    #1;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
  endtask
  // Reference model: payload chunks of four words, first word in the MSBs, zero padded,
  // truncated to MAXB blocks once the payload is longer than the FIFO allows
  task automatic send_pkt(input logic [31:0] cmd, input logic [31:0] pl[$], input int stall_at);
    int n = pl.size();
    int acc, t, start, nb;
    bit ovf;
    logic [127:0] b;
    done_t e;
    exp_cmd.push_back(cmd);
    ovf = n > 4 * MAXB;
    nb = ovf ? MAXB : (n + 3) / 4;
    for (int j = 0; j < nb; j++) begin
      b = '0;
      for (int k = 0; k < 4; k++) if (4 * j + k < n) b[127 - 32 * k -: 32] = pl[4 * j + k];
      exp_blk.push_back(b);
    end
    e.cnt = 12'(nb);
    e.perr = !ovf && (n % 4 != 0);
    e.oerr = ovf;
    exp_done.push_back(e);
    start = done_cnt;
    send_word(cmd, n == 0, acc);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        force_full = 1'b1;
        @(posedge clk);
        #3;
        s_if.tdata = pl[i];
        s_if.tlast = i == n - 1;
        s_if.tvalid = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("tready low while full", s_if.tready, 0);
        end
        force_full = 1'b0;
      end
      send_word(pl[i], i == n - 1, t);
    end
    t = 0;
    while (done_cnt == start && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("done pulse seen", done_cnt, start + 1);
    if (n == 0) chk("cmd-only done latency", done_cyc - acc, 2);
    repeat (3) begin
      @(negedge clk);
      chk("tready low in wait", s_if.tready, 0);
    end
    @(posedge clk);
    #1;
    axis_master_done = 1'b1;
    @(posedge clk);
    #1;
    axis_master_done = 1'b0;
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end
  initial begin
    logic [31:0] pl[$];
    int acc;
    s_if.tdata = '0;
    s_if.tvalid = 1'b0;
    s_if.tlast = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset outputs", {in_fifo_data, in_fifo_w_e, cmd_valid, axis_slave_done, err_partial, err_overflow}, 0);
    chk("reset cmd/cnt", {axis_cmd, blk_cnt}, 0);
    chk("reset tready", s_if.tready, 1);
    reset = 1'b0;
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back(32'(i));
    send_pkt(32'h10, pl, -1);
    pl = {};
    send_pkt(32'h20, pl, -1);
    pl = {32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
    send_pkt(32'h30, pl, -1);
    pl = {};
    for (int i = 0; i < 8; i++) pl.push_back($urandom);
    send_pkt(32'h40, pl, 3);
    pl = {};
    for (int i = 0; i < 12; i++) pl.push_back($urandom);
    send_pkt(32'h50, pl, -1);
    exp_cmd.push_back(32'h60);
    send_word(32'h60, 1'b0, acc);
    send_word(32'hDEAD0001, 1'b0, acc);
    send_word(32'hDEAD0002, 1'b0, acc);
    #3;
    reset = 1'b1;
    #1;
    chk("async reset outputs", {in_fifo_data, in_fifo_w_e, cmd_valid, axis_slave_done, err_partial, err_overflow}, 0);
    chk("async reset cmd/cnt", {axis_cmd, blk_cnt}, 0);
    chk("async reset tready", s_if.tready, 1);
    exp_blk.delete();
    exp_done.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    pl = {32'h1, 32'h2, 32'h3, 32'h4};
    send_pkt(32'h70, pl, -1);
    rand_full = 1;
    for (int p = 0; p < 40; p++) begin
      pl = {};
      repeat ($urandom_range(0, 13)) pl.push_back($urandom);
      send_pkt($urandom, pl, -1);
    end
    rand_full = 0;
    repeat (4) @(posedge clk);
    chk("scoreboard drained", exp_blk.size() + exp_cmd.size() + exp_done.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
